// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter with configurable frame, runtime baud divisor
//            and a valid/ready input buffered by a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [DIV_WIDTH-1:0]        i_clk_div,
  input  logic [DATA_BITS-1:0]        i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_busy,
  output logic                        o_tx
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_IW = $clog2(DATA_BITS);
  localparam logic [c_AW:0]          c_FULL      = c_CW'(FIFO_DEPTH);
  localparam logic [c_IW-1:0]        c_LAST_DATA = c_IW'(DATA_BITS - 1);
  localparam logic [c_IW-1:0]        c_LAST_STOP = c_IW'(STOP_BITS - 1);
  localparam logic [DIV_WIDTH-1:0]   c_DIV_MIN   = DIV_WIDTH'(2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr_ptr;
  logic [c_AW-1:0]      r_rd_ptr;
  logic [c_AW:0]        r_count;
  logic                 w_push;
  logic                 w_pop;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IW-1:0]      r_bit_idx;
  logic [c_IW-1:0]      w_bit_idx_nxt;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] w_div_sat;
  logic [DATA_BITS-1:0] r_data;
  logic                 w_tick;
  logic                 w_par_bit;

  assign w_push    = i_valid && (r_count != c_FULL);
  assign w_div_sat = (i_clk_div < c_DIV_MIN) ? c_DIV_MIN : i_clk_div;
  assign w_tick    = (r_cnt == '0);
  assign w_par_bit = (PARITY == 2) ? ~(^r_data) : (^r_data);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_bit_idx <= '0;
      r_cnt     <= '0;
      r_div     <= c_DIV_MIN;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_pop) begin
        r_data <= r_mem[r_rd_ptr];
        r_div  <= w_div_sat;
      end
    end
  end

  // A pop always starts a new frame: it reloads the divisor and bit timer.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_cnt_nxt     = r_cnt;
    w_pop         = 1'b0;
    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_tick ? (r_div - 1'b1) : (r_cnt - 1'b1);
    end
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_pop = 1'b1;
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == c_LAST_DATA) begin
            w_state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
            w_bit_idx_nxt = '0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt   = S_STOP;
          w_bit_idx_nxt = '0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bit_idx == c_LAST_STOP) begin
            if (r_count != '0) w_pop = 1'b1;
            else               w_state_nxt = S_IDLE;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_pop) begin
      w_state_nxt   = S_START;
      w_bit_idx_nxt = '0;
      w_cnt_nxt     = w_div_sat - 1'b1;
    end
  end

  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      S_START:  o_tx = 1'b0;
      S_DATA:   o_tx = r_data[r_bit_idx];
      S_PARITY: o_tx = w_par_bit;
      default:  o_tx = 1'b1;
    endcase
  end

  assign o_ready      = (r_count != c_FULL);
  assign o_fifo_count = r_count;
  assign o_busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench for uart_tx_fifo over several frame formats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int NCH = 6;
  localparam int c_DB  [NCH] = '{8, 8, 8, 8, 9, 5};
  localparam int c_PAR [NCH] = '{0, 1, 2, 0, 2, 1};
  localparam int c_SB  [NCH] = '{1, 1, 1, 2, 2, 1};

  logic                      clk = 1'b0;
  logic                      rst;
  logic [15:0]               clk_div;
  logic [8:0]                data_s [NCH];
  logic [NCH-1:0]            valid_s;
  logic [NCH-1:0]            tx_s;
  logic [NCH-1:0]            busy_s;
  logic [NCH-1:0]            ready_s;
  logic [NCH-1:0][2:0]       cnt_s;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic void check(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d @%0t: got %0h expected %0h", nm, ch, $time, act, exp);
    end
  endfunction

  // Line level of frame bit idx: start, data LSB first, optional parity, stop.
  function automatic bit frame_bit(input int d, input int db, input int par, input int idx);
    bit p;
    p = ($countones(d) % 2) == 1;
    if (idx == 0) return 1'b0;
    if (idx <= db) return bit'((d >> (idx - 1)) & 1);
    if (par != 0 && idx == db + 1) return (par == 1) ? p : !p;
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    uart_tx_fifo #(
      .DATA_BITS (c_DB[gi]),
      .PARITY    (c_PAR[gi]),
      .STOP_BITS (c_SB[gi]),
      .DIV_WIDTH (16),
      .FIFO_DEPTH(4)
    ) u_dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_clk_div   (clk_div),
      .i_data      (data_s[gi][c_DB[gi]-1:0]),
      .i_valid     (valid_s[gi]),
      .o_ready     (ready_s[gi]),
      .o_fifo_count(cnt_s[gi]),
      .o_busy      (busy_s[gi]),
      .o_tx        (tx_s[gi])
    );

    // Reference: queue of buffered words plus the per-clock line levels still to send.
    int mq[$];
    bit lq[$];

    always @(posedge clk) begin
      int d, dv, nb;
      bit acc;
      if (rst) begin
        mq.delete();
        lq.delete();
      end else begin
        acc = valid_s[gi] && (mq.size() != 4);
        if (lq.size() != 0) void'(lq.pop_front());
        if (lq.size() == 0 && mq.size() != 0) begin
          d  = mq.pop_front();
          dv = (clk_div < 16'd2) ? 2 : int'(clk_div);
          nb = 1 + c_DB[gi] + ((c_PAR[gi] != 0) ? 1 : 0) + c_SB[gi];
          for (int b = 0; b < nb; b++)
            for (int k = 0; k < dv; k++)
              lq.push_back(frame_bit(d, c_DB[gi], c_PAR[gi], b));
        end
        if (acc) mq.push_back(int'(data_s[gi]) & ((1 << c_DB[gi]) - 1));
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check("tx",    gi, 32'(tx_s[gi]),    32'((lq.size() != 0) ? lq[0] : 1'b1));
        check("busy",  gi, 32'(busy_s[gi]),  32'((lq.size() != 0) || (mq.size() != 0)));
        check("count", gi, 32'(cnt_s[gi]),   32'(mq.size()));
        check("ready", gi, 32'(ready_s[gi]), 32'(mq.size() != 4));
      end
    end
  end

  typedef struct {
    int ch;
    int data;
    int div;
    int eff;
    int nb;
    int bits;
  } vec_t;

  vec_t tbl [8];

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_s != '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_s != '0) check("idle_timeout", -1, 32'(busy_s), 32'(0));
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    bit eb;
    wait_idle(2000);
    clk_div = 16'(v.div);
    data_s[v.ch] = 9'(v.data);
    valid_s[v.ch] = 1'b1;
    @(negedge clk);
    valid_s[v.ch] = 1'b0;
    check("vec_cnt", v.ch, 32'(cnt_s[v.ch]), 32'(1));
    @(negedge clk);
    for (int b = 0; b < v.nb; b++) begin
      eb = v.bits[b];
      ok = 1'b1;
      for (int k = 0; k < v.eff; k++) begin
        if (tx_s[v.ch] !== eb) ok = 1'b0;
        @(negedge clk);
      end
      check("vec_bit", v.ch, 32'(ok ? eb : !eb), 32'(eb));
    end
    check("vec_busy_end", v.ch, 32'(busy_s[v.ch]), 32'(0));
  endtask

  initial begin
    int  w4 [6];
    int  idx, first_low, busy_hi, lows;
    bit  was_ready;

    tbl[0] = '{ch:0, data:'h055, div:4, eff:4, nb:10, bits:'h02AA};
    tbl[1] = '{ch:1, data:'h007, div:3, eff:3, nb:11, bits:'h060E};
    tbl[2] = '{ch:2, data:'h007, div:3, eff:3, nb:11, bits:'h040E};
    tbl[3] = '{ch:3, data:'h0A3, div:5, eff:5, nb:11, bits:'h0746};
    tbl[4] = '{ch:0, data:'h0FF, div:1, eff:2, nb:10, bits:'h03FE};
    tbl[5] = '{ch:0, data:'h0FF, div:0, eff:2, nb:10, bits:'h03FE};
    tbl[6] = '{ch:5, data:'h013, div:2, eff:2, nb:8,  bits:'h00E6};
    tbl[7] = '{ch:4, data:'h1F0, div:2, eff:2, nb:13, bits:'h1BE0};
    w4 = '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66};

    rst = 1'b1;
    clk_div = 16'd4;
    valid_s = '0;
    for (int c = 0; c < NCH; c++) data_s[c] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_tx",    0, 32'(tx_s[0]),    32'(1));
    check("rst_ready", 0, 32'(ready_s[0]), 32'(1));
    check("rst_busy",  0, 32'(busy_s[0]),  32'(0));
    check("rst_count", 0, 32'(cnt_s[0]),   32'(0));

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Six words back to back: ready drops after the fifth accept, frames contiguous.
    wait_idle(2000);
    clk_div = 16'd4;
    idx = 0;
    first_low = -1;
    busy_hi = 0;
    was_ready = ready_s[0];
    valid_s[0] = 1'b1;
    data_s[0] = 9'(w4[0]);
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      if (idx < 6) begin
        if (was_ready) idx++;
        if (!ready_s[0] && first_low < 0) first_low = idx;
        if (idx >= 6) valid_s[0] = 1'b0;
        else          data_s[0] = 9'(w4[idx]);
        was_ready = ready_s[0];
      end
      if (busy_s[0]) busy_hi++;
      else if (idx >= 6) break;
    end
    check("burst_accepted",  0, 32'(idx),       32'(6));
    check("burst_ready_low", 0, 32'(first_low), 32'(5));
    check("burst_busy_len",  0, 32'(busy_hi),   32'(241));

    // Reset in the middle of data bit 3 with two words still queued.
    wait_idle(2000);
    clk_div = 16'd4;
    valid_s[0] = 1'b1;
    data_s[0] = 9'h0F0;
    @(negedge clk);
    data_s[0] = 9'h0AA;
    @(negedge clk);
    data_s[0] = 9'h0BB;
    @(negedge clk);
    valid_s[0] = 1'b0;
    check("pre_rst_count", 0, 32'(cnt_s[0]), 32'(2));
    repeat (16) @(negedge clk);
    check("pre_rst_busy", 0, 32'(busy_s[0]), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_tx",    0, 32'(tx_s[0]),    32'(1));
    check("post_rst_count", 0, 32'(cnt_s[0]),   32'(0));
    check("post_rst_busy",  0, 32'(busy_s[0]),  32'(0));
    check("post_rst_ready", 0, 32'(ready_s[0]), 32'(1));
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_s[0] !== 1'b1 || busy_s[0] !== 1'b0) lows++;
    end
    check("post_rst_quiet", 0, 32'(lows), 32'(0));

    // Divisor change mid-frame applies only to the following frame.
    wait_idle(2000);
    clk_div = 16'd4;
    valid_s[0] = 1'b1;
    data_s[0] = 9'h055;
    busy_hi = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (t == 0) data_s[0] = 9'h001;
      if (t == 1) valid_s[0] = 1'b0;
      if (t == 5) clk_div = 16'd8;
      if (busy_s[0]) busy_hi++;
      else break;
    end
    check("divchg_busy_len", 0, 32'(busy_hi), 32'(121));

    // Randomised traffic on every format against the reference queues.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 250 == 0) clk_div = 16'($urandom_range(0, 5));
      for (int ch = 0; ch < NCH; ch++) begin
        valid_s[ch] = ($urandom_range(0, 3) == 0);
        data_s[ch]  = 9'($urandom);
      end
    end
    valid_s = '0;
    wait_idle(5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
